// File: rtl/wb_regfile_pkg.sv
// Shared widths and control encodings for the write-back register file.
package wb_regfile_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [RegBus-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;
    localparam logic RstEnable    = 1'b1;

endpackage

// File: rtl/wb_hilo_reg.sv
// HI/LO special registers with optional write-to-read bypass.
// Bypass is compiled in when WB_REGFILE_BYPASS_EN is defined.
module wb_hilo_reg
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = RegBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (whilo != WriteDisable) begin
            hi_q <= hi_i;
            lo_q <= lo_i;
        end
    end

    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (rst == RstEnable) begin
            hi_o = '0;
            lo_o = '0;
        end
`ifdef WB_REGFILE_BYPASS_EN
        else if (whilo == WriteEnable) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end
`endif
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back sink: 2**ADDR_W x DATA_W GPR file, HI/LO, retired-write counter.
// Define WB_REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [31:0]       retire_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] gpr [NREG];
    logic              gpr_wr;
    logic              retire;

    assign gpr_wr = (we == WriteEnable) && (waddr != NOPRegAddr);
    assign retire = (we == WriteEnable) || (whilo == WriteEnable);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < NREG; i++) gpr[i] <= ZeroWord;
        end else if (gpr_wr) begin
            gpr[waddr] <= wdata;
        end
    end

    // Counter wraps naturally; writes to r0 still count as retired.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) retire_cnt <= '0;
        else if (retire)      retire_cnt <= retire_cnt + 32'd1;
    end

    always_comb begin
        rdata1 = gpr[raddr1];
        if (rst == RstEnable)           rdata1 = ZeroWord;
        else if (re1 == ReadDisable)    rdata1 = ZeroWord;
        else if (raddr1 == NOPRegAddr)  rdata1 = ZeroWord;
`ifdef WB_REGFILE_BYPASS_EN
        else if (re1 == ReadEnable && we == WriteEnable && raddr1 == waddr)
            rdata1 = wdata;
`endif
    end

    always_comb begin
        rdata2 = gpr[raddr2];
        if (rst == RstEnable)           rdata2 = ZeroWord;
        else if (re2 == ReadDisable)    rdata2 = ZeroWord;
        else if (raddr2 == NOPRegAddr)  rdata2 = ZeroWord;
`ifdef WB_REGFILE_BYPASS_EN
        else if (re2 == ReadEnable && we == WriteEnable && raddr2 == waddr)
            rdata2 = wdata;
`endif
    end

    wb_hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk   (clk),
        .rst   (rst),
        .whilo (whilo),
        .hi_i  (hi_i),
        .lo_i  (lo_i),
        .hi_o  (hi_o),
        .lo_o  (lo_o)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile against an array-based reference model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_gpr [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_cnt;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .whilo      (whilo),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .re1        (re1),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .re2        (re2),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    // Expected combinational read value from the architectural rules.
    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] ra);
        if (rst) return 32'h0;
        if (!re) return 32'h0;
        if (ra == 5'd0) return 32'h0;
        if (BYP && we && waddr == ra) return wdata;
        return m_gpr[ra];
    endfunction

    function automatic logic [31:0] exp_hi();
        if (rst) return 32'h0;
        if (BYP && whilo) return hi_i;
        return m_hi;
    endfunction

    function automatic logic [31:0] exp_lo();
        if (rst) return 32'h0;
        if (BYP && whilo) return lo_i;
        return m_lo;
    endfunction

    task automatic idle();
        we = 0; waddr = 0; wdata = 0; whilo = 0; hi_i = 0; lo_i = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
            m_hi = 0; m_lo = 0; m_cnt = 0;
        end else begin
            if (we && waddr != 0) m_gpr[waddr] = wdata;
            if (whilo) begin m_hi = hi_i; m_lo = lo_i; end
            if (we || whilo) m_cnt = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; idle(); re1 = 1; raddr1 = 3; re2 = 1; raddr2 = 3;
        tick(); tick();
        rst = 0; #2;
        checks++; if (retire_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt_init got %h exp %h", retire_cnt, 32'h0); end
        checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin errors++; $display("FAIL reset_hilo_init got %h/%h exp 0/0", hi_o, lo_o); end
        we = 1; waddr = 3; wdata = 32'h12345678; whilo = 1; hi_i = 32'hAAAA0000; lo_i = 32'h5555;
        tick(); idle(); #2;
        checks++; if (rdata1 !== 32'h12345678) begin errors++; $display("FAIL reset_pre_gpr3 got %h exp %h", rdata1, 32'h12345678); end
        rst = 1; #2;
        checks++; if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin errors++; $display("FAIL reset_rd_forced got %h/%h exp 0/0", rdata1, rdata2); end
        checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin errors++; $display("FAIL reset_hilo_forced got %h/%h exp 0/0", hi_o, lo_o); end
        tick(); rst = 0; #2;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_gpr3_cleared got %h exp 0", rdata1); end
        checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0 || retire_cnt !== 32'h0) begin errors++; $display("FAIL reset_state_cleared got hi %h lo %h cnt %h exp 0", hi_o, lo_o, retire_cnt); end
    endtask

    task automatic test_basic();
        idle(); we = 1; waddr = 5; wdata = 32'hDEADBEEF; re1 = 0;
        tick(); idle(); re1 = 1; raddr1 = 5; #2;
        checks++; if (rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_read got %h exp %h", rdata1, 32'hDEADBEEF); end
        re1 = 0; #2;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL basic_re_off got %h exp 0", rdata1); end
    endtask

    task automatic test_reg0_nop();
        logic [31:0] c0;
        c0 = m_cnt;
        idle(); we = 1; waddr = 0; wdata = 32'hFFFFFFFF; re1 = 1; raddr1 = 0; #2;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reg0_same_cycle got %h exp 0", rdata1); end
        tick(); idle(); #2;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reg0_after got %h exp 0", rdata1); end
        checks++; if (retire_cnt !== c0 + 32'd1) begin errors++; $display("FAIL reg0_counts got %h exp %h", retire_cnt, c0 + 32'd1); end
        tick(); #2;
        checks++; if (retire_cnt !== c0 + 32'd1) begin errors++; $display("FAIL nop_no_count got %h exp %h", retire_cnt, c0 + 32'd1); end
    endtask

    task automatic test_bypass();
        idle(); we = 1; waddr = 7; wdata = 32'h1;
        tick();
        wdata = 32'h2; re1 = 1; re2 = 1; raddr1 = 7; raddr2 = 7; #2;
        checks++; if (rdata1 !== (BYP ? 32'h2 : 32'h1)) begin errors++; $display("FAIL bypass_p1 got %h exp %h", rdata1, BYP ? 32'h2 : 32'h1); end
        checks++; if (rdata2 !== (BYP ? 32'h2 : 32'h1)) begin errors++; $display("FAIL bypass_p2 got %h exp %h", rdata2, BYP ? 32'h2 : 32'h1); end
        tick(); idle(); #2;
        checks++; if (rdata1 !== 32'h2 || rdata2 !== 32'h2) begin errors++; $display("FAIL bypass_next got %h/%h exp 2/2", rdata1, rdata2); end
    endtask

    task automatic test_hilo();
        logic [31:0] c0;
        c0 = m_cnt;
        idle(); whilo = 1; hi_i = 32'h1; lo_i = 32'h2; we = 1; waddr = 9; wdata = 32'h3; #2;
        checks++; if (hi_o !== (BYP ? 32'h1 : m_hi) || lo_o !== (BYP ? 32'h2 : m_lo)) begin errors++; $display("FAIL hilo_same_cycle got %h/%h exp %h/%h", hi_o, lo_o, BYP ? 32'h1 : m_hi, BYP ? 32'h2 : m_lo); end
        tick(); idle(); re1 = 1; raddr1 = 9; #2;
        checks++; if (hi_o !== 32'h1 || lo_o !== 32'h2) begin errors++; $display("FAIL hilo_next got %h/%h exp 1/2", hi_o, lo_o); end
        checks++; if (rdata1 !== 32'h3) begin errors++; $display("FAIL hilo_gpr9 got %h exp 3", rdata1); end
        checks++; if (retire_cnt !== c0 + 32'd1) begin errors++; $display("FAIL hilo_count_once got %h exp %h", retire_cnt, c0 + 32'd1); end
    endtask

    task automatic test_wrap();
        idle();
        force dut.retire_cnt = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt;
        m_cnt = 32'hFFFFFFFF;
        we = 1; waddr = 10; wdata = $urandom;
        tick(); idle(); #2;
        checks++; if (retire_cnt !== 32'h0) begin errors++; $display("FAIL wrap got %h exp 0", retire_cnt); end
    endtask

    task automatic test_reset_collision();
        idle(); rst = 1; we = 1; waddr = 4; wdata = 32'hCAFEF00D;
        tick(); rst = 0; idle(); re1 = 1; raddr1 = 4; #2;
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL rst_collision_gpr4 got %h exp 0", rdata1); end
        checks++; if (retire_cnt !== 32'h0) begin errors++; $display("FAIL rst_collision_cnt got %h exp 0", retire_cnt); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 49) == 0);
            we     = $urandom_range(0, 1);
            waddr  = 5'($urandom_range(0, 31));
            wdata  = $urandom;
            whilo  = ($urandom_range(0, 3) == 0);
            hi_i   = $urandom;
            lo_i   = $urandom;
            re1    = ($urandom_range(0, 7) != 0);
            re2    = ($urandom_range(0, 7) != 0);
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
            #2;
            checks++; if (rdata1 !== exp_rd(re1, raddr1)) begin errors++; $display("FAIL rand_rd1[%0d] got %h exp %h", n, rdata1, exp_rd(re1, raddr1)); end
            checks++; if (rdata2 !== exp_rd(re2, raddr2)) begin errors++; $display("FAIL rand_rd2[%0d] got %h exp %h", n, rdata2, exp_rd(re2, raddr2)); end
            checks++; if (hi_o !== exp_hi() || lo_o !== exp_lo()) begin errors++; $display("FAIL rand_hilo[%0d] got %h/%h exp %h/%h", n, hi_o, lo_o, exp_hi(), exp_lo()); end
            checks++; if (retire_cnt !== m_cnt) begin errors++; $display("FAIL rand_cnt[%0d] got %h exp %h", n, retire_cnt, m_cnt); end
            tick();
        end
        rst = 0; idle();
    endtask

    initial begin
        rst = 1; idle(); re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
        m_hi = 0; m_lo = 0; m_cnt = 0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_reg0_nop();
        test_bypass();
        test_hilo();
        test_wrap();
        test_reset_collision();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
